// File: rtl/shr_pkg.sv
// rtl/shr_pkg.sv - shared types, default width and stage-count helper for the shr_seq shifter
package shr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } shr_state_t;

  localparam int WIDTH_DEF = 32;

  function automatic int shr_shw(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/shr_stage.sv
// rtl/shr_stage.sv - one combinational right-shift stage of 2^K bits with a supplied fill bit
module shr_stage #(
  parameter int WIDTH = 32,
  parameter int K     = 0
) (
  input  logic [WIDTH-1:0] in,
  input  logic             en,
  input  logic             fill,
  output logic [WIDTH-1:0] out
);

  localparam int S = 1 << K;

  assign out = en ? {{S{fill}}, in[WIDTH-1:S]} : in;

endmodule

// File: rtl/shr_seq.sv
// rtl/shr_seq.sv - multi-cycle right shifter, one binary stage per cycle; SHR_ARITH_EN adds the arith port
module shr_seq
  import shr_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEF,
  localparam int SHW   = shr_shw(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [SHW-1:0]   amt,
`ifdef SHR_ARITH_EN
  input  logic             arith,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out
);

  shr_state_t       r_state;
  shr_state_t       w_state_n;
  logic [SHW-1:0]   r_idx;
  logic [WIDTH-1:0] r_data;
  logic [SHW-1:0]   r_amt;
  logic             r_fill;
  logic [WIDTH-1:0] r_out;
  logic             w_accept;
  logic             w_last;
  logic             w_fill_in;
  logic [WIDTH-1:0] w_shift;
  logic [WIDTH-1:0] w_stage [SHW];

`ifdef SHR_ARITH_EN
  assign w_fill_in = arith & in[WIDTH-1];
`else
  assign w_fill_in = 1'b0;
`endif

  // DONE does not block a new request, so back-to-back starts lose no cycle
  assign w_accept = start && (r_state != SHIFT);
  assign w_last   = (r_state == SHIFT) && (r_idx == '0);

  genvar g;
  generate
    for (g = 0; g < SHW; g++) begin : g_stage
      shr_stage #(.WIDTH(WIDTH), .K(g)) u_stage (
        .in   (r_data),
        .en   (r_amt[g]),
        .fill (r_fill),
        .out  (w_stage[g])
      );
    end
  endgenerate

  always_comb begin
    w_shift = r_data;
    for (int k = 0; k < SHW; k++) begin
      if (r_idx == SHW'(k)) w_shift = w_stage[k];
    end
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      IDLE:    if (start) w_state_n = SHIFT;
      SHIFT:   if (w_last) w_state_n = DONE;
      DONE:    w_state_n = start ? SHIFT : IDLE;
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx  <= SHW'(SHW - 1);
      r_data <= '0;
      r_amt  <= '0;
      r_fill <= 1'b0;
      r_out  <= '0;
    end else if (w_accept) begin
      r_idx  <= SHW'(SHW - 1);
      r_data <= in;
      r_amt  <= amt;
      r_fill <= w_fill_in;
    end else if (r_state == SHIFT) begin
      r_data <= w_shift;
      if (w_last) r_out <= w_shift;
      else        r_idx <= r_idx - 1'b1;
    end
  end

  assign busy = (r_state == SHIFT);
  assign done = (r_state == DONE);
  assign out  = r_out;

endmodule

// File: tb/tb_shr_seq.sv
// tb/tb_shr_seq.sv - directed self-checking bench for shr_seq (arith case only with SHR_ARITH_EN)
module tb_shr_seq;

  localparam int W   = 32;
  localparam int SW  = 5;
  localparam int LAT = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  din;
  logic [SW-1:0] amt;
`ifdef SHR_ARITH_EN
  logic          arith;
`endif
  logic          busy;
  logic          done;
  logic [W-1:0]  dout;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  shr_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .in    (din),
    .amt   (amt),
`ifdef SHR_ARITH_EN
    .arith (arith),
`endif
    .busy  (busy),
    .done  (done),
    .out   (dout)
  );

  task automatic start_op(input logic [W-1:0] a, input logic [SW-1:0] s);
    @(negedge clk);
    start = 1'b1; din = a; amt = s;
    @(posedge clk); #1;
    start = 1'b0; din = $urandom; amt = SW'($urandom_range(0, 31));
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; din = '0; amt = '0;
`ifdef SHR_ARITH_EN
    arith = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (dout !== '0) begin errors++; $display("FAIL reset_out got=%h exp=0", dout); end
  endtask

  task automatic test_timing;
    int lat;
    start_op(32'hFFFF_FFFF, 5'd8);
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL t1_busy_start busy=%b done=%b exp busy=1 done=0", busy, done); end
    wait_done(lat);
    checks++; if (lat !== LAT) begin errors++; $display("FAIL t1_latency got=%0d exp=%0d", lat, LAT); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t1_busy_done got=%b exp=0", busy); end
    checks++; if (dout !== 32'h00FF_FFFF) begin errors++; $display("FAIL t1_out got=%h exp=00ffffff", dout); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0 || dout !== 32'h00FF_FFFF) begin errors++; $display("FAIL t1_hold done=%b out=%h exp done=0 out=00ffffff", done, dout); end
  endtask

  task automatic test_amt_zero;
    int lat;
    start_op(32'h1234_5678, 5'd0);
    @(posedge clk); #1;
    checks++; if (dout !== 32'h00FF_FFFF) begin errors++; $display("FAIL t2_old_out got=%h exp=00ffffff", dout); end
    wait_done(lat);
    checks++; if (lat !== LAT - 1) begin errors++; $display("FAIL t2_latency got=%0d exp=%0d", lat, LAT - 1); end
    checks++; if (dout !== 32'h1234_5678) begin errors++; $display("FAIL t2_out got=%h exp=12345678", dout); end
  endtask

  task automatic test_vectors;
    logic [W-1:0]  v_in  [5] = '{32'h8000_0000, 32'hA5A5_A5A5, 32'hDEAD_BEEF, 32'h1234_5678, 32'hFFFF_FFFF};
    logic [SW-1:0] v_amt [5] = '{5'd31, 5'd1, 5'd16, 5'd13, 5'd31};
    logic [W-1:0]  v_exp [5] = '{32'h0000_0001, 32'h52D2_D2D2, 32'h0000_DEAD, 32'h0000_91A2, 32'h0000_0001};
    int lat;
    for (int i = 0; i < 5; i++) begin
      start_op(v_in[i], v_amt[i]);
      wait_done(lat);
      checks++; if (dout !== v_exp[i] || lat !== LAT) begin errors++; $display("FAIL vec%0d out=%h lat=%0d exp out=%h lat=%0d", i, dout, lat, v_exp[i], LAT); end
    end
`ifdef SHR_ARITH_EN
    arith = 1'b1;
    start_op(32'h8000_0000, 5'd31);
    arith = 1'b0;
    wait_done(lat);
    checks++; if (dout !== 32'hFFFF_FFFF) begin errors++; $display("FAIL t3_arith got=%h exp=ffffffff", dout); end
`endif
  endtask

  task automatic test_busy_ignore;
    int lat;
    int extra;
    start_op(32'h0000_0001, 5'd0);
    @(negedge clk);
    start = 1'b1; din = 32'hFFFF_FFFF; amt = 5'd0;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    checks++; if (dout !== 32'h0000_0001 || lat !== LAT - 1) begin errors++; $display("FAIL t4_out out=%h lat=%0d exp out=00000001 lat=%0d", dout, lat, LAT - 1); end
    extra = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    checks++; if (extra !== 0 || busy !== 1'b0) begin errors++; $display("FAIL t4_ignored extra_done=%0d busy=%b exp 0 0", extra, busy); end
  endtask

  task automatic test_abort;
    int seen;
    int lat;
    start_op(32'hFFFF_FFFF, 5'd8);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || dout !== '0) begin errors++; $display("FAIL t5_abort busy=%b done=%b out=%h exp 0 0 0", busy, done, dout); end
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL t5_no_done got=%0d exp=0", seen); end
    start_op(32'hFFFF_FFFF, 5'd4);
    wait_done(lat);
    checks++; if (dout !== 32'h0FFF_FFFF || lat !== LAT) begin errors++; $display("FAIL t5_recover out=%h lat=%0d exp out=0fffffff lat=%0d", dout, lat, LAT); end
  endtask

  task automatic test_back_to_back;
    int lat;
    int gap;
    @(negedge clk);
    start = 1'b1; din = 32'hF000_0000; amt = 5'd4;
    @(posedge clk); #1;
    wait_done(lat);
    checks++; if (dout !== 32'h0F00_0000 || lat !== LAT) begin errors++; $display("FAIL t6_first out=%h lat=%0d exp out=0f000000 lat=%0d", dout, lat, LAT); end
    gap = 0;
    do begin
      @(posedge clk); #1;
      gap++;
    end while (!done && gap < 20);
    start = 1'b0;
    checks++; if (gap !== LAT + 1) begin errors++; $display("FAIL t6_gap got=%0d exp=%0d", gap, LAT + 1); end
    checks++; if (dout !== 32'h0F00_0000) begin errors++; $display("FAIL t6_second got=%h exp=0f000000", dout); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL t6_idle busy=%b done=%b exp 0 0", busy, done); end
  endtask

  initial begin
    test_reset;
    test_timing;
    test_amt_zero;
    test_vectors;
    test_busy_ignore;
    test_abort;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
